// File: rtl/ap_ctrl_status_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ap_ctrl_status_tracker_pkg
// Shared types and defaults for the HLS block-level handshake monitor.
//   start_state_t : start-request tracking states (IDLE, PENDING)
//   rec_t         : one completed-transaction record {index, latency, interval}
//                   at the default counter width
//   DEFAULT_CNT_W : default width of counters, timestamps and statistics
//   DEFAULT_DEPTH : default in-flight FIFO depth (power of two >= 2)
// ---------------------------------------------------------------------------
package ap_ctrl_status_tracker_pkg;

    localparam int DEFAULT_CNT_W = 32;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } start_state_t;

    typedef struct packed {
        logic [DEFAULT_CNT_W-1:0] index;
        logic [DEFAULT_CNT_W-1:0] latency;
        logic [DEFAULT_CNT_W-1:0] interval;
    } rec_t;

endpackage

// File: rtl/ap_ctrl_status_tracker_if.sv
// ---------------------------------------------------------------------------
// ap_ctrl_status_tracker_if
// Bundles the watched block's ap_ctrl handshake plus the common finish line.
//   master : drives ap_start, ap_ready, ap_done, ap_continue, finish
//            (the harness / watched block side)
//   slave  : observes the same signals (the monitor side)
// ---------------------------------------------------------------------------
interface ap_ctrl_status_tracker_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;
    logic finish;

    modport master (
        output ap_start,
        output ap_ready,
        output ap_done,
        output ap_continue,
        output finish
    );

    modport slave (
        input ap_start,
        input ap_ready,
        input ap_done,
        input ap_continue,
        input finish
    );

endinterface

// File: rtl/ap_ctrl_status_tracker_ts_fifo.sv
// ---------------------------------------------------------------------------
// ts_fifo
// Synchronous DEPTH-entry FIFO holding {t_s, interval} of accepted but not yet
// completed transactions. Push and pop may occur in the same cycle, including
// when full (the slot being read is the one overwritten at the edge).
//   clock, reset : clock and asynchronous active-high reset
//   push, pop    : write / read requests (push ignored when full without pop,
//                  pop ignored when empty)
//   din, dout    : write data / head-of-queue data (dout valid when !empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ts_fifo
    import ap_ctrl_status_tracker_pkg::*;
#(
    parameter int W     = 2 * DEFAULT_CNT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    // Storage carries no reset so it maps onto distributed RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ap_ctrl_status_tracker.sv
// ---------------------------------------------------------------------------
// ap_ctrl_status_tracker
// Monitor for one HLS ap_ctrl handshake. Timestamps accepted transactions,
// matches them in order to completions (ap_done & ap_continue) through an
// in-flight FIFO and emits one record per completion plus running statistics.
//   clock, reset  : clock, asynchronous active-high reset
//   hs            : handshake + finish (slave modport)
//   rec_valid     : one-cycle pulse, one cycle after the completion cycle
//   rec_index     : 0-based completion index
//   rec_latency   : cycles from start request to completion (min 1)
//   rec_interval  : cycles since the previous accept (0 for the first)
//   started_cnt   : accepted transactions (overflowed ones included)
//   done_cnt      : recorded completions
//   min_lat/max_lat : latency extremes (min starts at all-ones)
//   stall_cycles  : cycles with ap_done=1 and ap_continue=0
//   in_flight     : FIFO occupancy
//   busy          : start pending or anything in flight
//   overflow, underflow, finished : sticky flags
// ---------------------------------------------------------------------------
module ap_ctrl_status_tracker
    import ap_ctrl_status_tracker_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    ap_ctrl_status_tracker_if.slave  hs,
    output logic                     rec_valid,
    output logic [CNT_W-1:0]         rec_index,
    output logic [CNT_W-1:0]         rec_latency,
    output logic [CNT_W-1:0]         rec_interval,
    output logic [CNT_W-1:0]         started_cnt,
    output logic [CNT_W-1:0]         done_cnt,
    output logic [CNT_W-1:0]         min_lat,
    output logic [CNT_W-1:0]         max_lat,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [$clog2(DEPTH):0]   in_flight,
    output logic                     busy,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     finished
);

    start_state_t     state_reg, state_next;
    logic [CNT_W-1:0] pend_ts_reg, pend_ts_next;

    logic [CNT_W-1:0] now_reg;
    logic [CNT_W-1:0] last_acc_reg;
    logic             has_acc_reg;

    logic             rec_valid_reg;
    logic [CNT_W-1:0] rec_index_reg, rec_latency_reg, rec_interval_reg;
    logic [CNT_W-1:0] started_reg, done_reg, min_reg, max_reg, stall_reg;
    logic             overflow_reg, underflow_reg, finished_reg;

    logic             active;
    logic             accept;
    logic [CNT_W-1:0] accept_ts;
    logic             complete;
    logic             bypass;
    logic             do_push, do_pop;
    logic             rec_fire;
    logic [CNT_W-1:0] interval;
    logic [CNT_W-1:0] rec_ts, rec_int, rec_lat;

    logic [2*CNT_W-1:0] fifo_dout;
    logic               fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    // Once finish has been seen (or is being seen) nothing else moves.
    assign active = ~finished_reg & ~hs.finish;

    // ---------------- start state machine: next state ----------------
    always_comb begin
        state_next   = state_reg;
        pend_ts_next = pend_ts_reg;
        accept       = 1'b0;
        accept_ts    = now_reg;
        case (state_reg)
            IDLE: begin
                if (hs.ap_start) begin
                    if (hs.ap_ready) begin
                        accept = 1'b1;
                    end else begin
                        state_next   = PENDING;
                        pend_ts_next = now_reg;
                    end
                end
            end
            PENDING: begin
                // Ready wins over a simultaneous start drop: the block took it.
                if (hs.ap_ready) begin
                    accept     = 1'b1;
                    accept_ts  = pend_ts_reg;
                    state_next = IDLE;
                end else if (!hs.ap_start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- start state machine: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            pend_ts_reg <= '0;
        end else if (active) begin
            state_reg   <= state_next;
            pend_ts_reg <= pend_ts_next;
        end
    end

    // ---------------- accept / completion datapath ----------------
    assign complete = hs.ap_done & hs.ap_continue;
    assign interval = has_acc_reg ? (now_reg - last_acc_reg) : '0;

    // Same-cycle accept and completion with nothing queued: the record is
    // built straight from the accept and the FIFO is never touched.
    assign bypass   = accept & complete & fifo_empty;
    assign do_pop   = active & complete & ~fifo_empty;
    assign do_push  = active & accept & ~bypass;
    assign rec_fire = active & complete & (~fifo_empty | accept);

    assign rec_ts  = fifo_empty ? accept_ts : fifo_dout[2*CNT_W-1:CNT_W];
    assign rec_int = fifo_empty ? interval  : fifo_dout[CNT_W-1:0];
    assign rec_lat = now_reg - rec_ts + CNT_W'(1);

    ts_fifo #(
        .W     (2 * CNT_W),
        .DEPTH (DEPTH)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .din   ({accept_ts, interval}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            now_reg          <= '0;
            last_acc_reg     <= '0;
            has_acc_reg      <= 1'b0;
            rec_valid_reg    <= 1'b0;
            rec_index_reg    <= '0;
            rec_latency_reg  <= '0;
            rec_interval_reg <= '0;
            started_reg      <= '0;
            done_reg         <= '0;
            min_reg          <= '1;
            max_reg          <= '0;
            stall_reg        <= '0;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
            finished_reg     <= 1'b0;
        end else begin
            rec_valid_reg <= 1'b0;
            if (hs.finish) begin
                finished_reg <= 1'b1;
            end
            if (active) begin
                now_reg <= now_reg + CNT_W'(1);
                if (accept) begin
                    started_reg  <= started_reg + CNT_W'(1);
                    last_acc_reg <= now_reg;
                    has_acc_reg  <= 1'b1;
                end
                if (rec_fire) begin
                    rec_valid_reg    <= 1'b1;
                    rec_index_reg    <= done_reg;
                    rec_latency_reg  <= rec_lat;
                    rec_interval_reg <= rec_int;
                    done_reg         <= done_reg + CNT_W'(1);
                    if (rec_lat < min_reg) begin
                        min_reg <= rec_lat;
                    end
                    if (rec_lat > max_reg) begin
                        max_reg <= rec_lat;
                    end
                end
                if (complete && fifo_empty && !accept) begin
                    underflow_reg <= 1'b1;
                end
                if (do_push && fifo_full && !do_pop) begin
                    overflow_reg <= 1'b1;
                end
                if (hs.ap_done && !hs.ap_continue) begin
                    stall_reg <= stall_reg + CNT_W'(1);
                end
            end
        end
    end

    assign rec_valid    = rec_valid_reg;
    assign rec_index    = rec_index_reg;
    assign rec_latency  = rec_latency_reg;
    assign rec_interval = rec_interval_reg;
    assign started_cnt  = started_reg;
    assign done_cnt     = done_reg;
    assign min_lat      = min_reg;
    assign max_lat      = max_reg;
    assign stall_cycles = stall_reg;
    assign in_flight    = fifo_count;
    assign busy         = (state_reg == PENDING) || (fifo_count != '0);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign finished     = finished_reg;

endmodule

// File: tb/tb_ap_ctrl_status_tracker.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_status_tracker
// Directed scenarios followed by randomized handshake traffic, all compared
// cycle by cycle against a queue-based behavioural model of the monitor.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_status_tracker;
    import ap_ctrl_status_tracker_pkg::*;

    localparam int CNT_W = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ap_ctrl_status_tracker_if hs();

    logic             rec_valid;
    logic [CNT_W-1:0] rec_index, rec_latency, rec_interval;
    logic [CNT_W-1:0] started_cnt, done_cnt, min_lat, max_lat, stall_cycles;
    logic [CW-1:0]    in_flight;
    logic             busy, overflow, underflow, finished;

    ap_ctrl_status_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .hs           (hs),
        .rec_valid    (rec_valid),
        .rec_index    (rec_index),
        .rec_latency  (rec_latency),
        .rec_interval (rec_interval),
        .started_cnt  (started_cnt),
        .done_cnt     (done_cnt),
        .min_lat      (min_lat),
        .max_lat      (max_lat),
        .stall_cycles (stall_cycles),
        .in_flight    (in_flight),
        .busy         (busy),
        .overflow     (overflow),
        .underflow    (underflow),
        .finished     (finished)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_val(input string tag, input logic [CNT_W-1:0] got,
                             input logic [CNT_W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [CNT_W-1:0] m_now, m_pend_ts, m_last_acc;
    logic [CNT_W-1:0] m_started, m_done, m_min, m_max, m_stall;
    bit               m_pending, m_has_acc, m_ovf, m_unf, m_fin, m_rec_valid;
    rec_t             m_rec;
    logic [2*CNT_W-1:0] m_q[$];   // {start time, interval} of in-flight work

    task automatic model_reset();
        m_now = 0; m_pend_ts = 0; m_last_acc = 0;
        m_started = 0; m_done = 0; m_min = '1; m_max = 0; m_stall = 0;
        m_pending = 0; m_has_acc = 0; m_ovf = 0; m_unf = 0; m_fin = 0;
        m_rec_valid = 0; m_rec = '0;
        m_q.delete();
    endtask

    task automatic model_record(input logic [CNT_W-1:0] ts, input logic [CNT_W-1:0] ival);
        logic [CNT_W-1:0] lat;
        lat = m_now - ts + 1;
        m_rec.index    = m_done;
        m_rec.latency  = lat;
        m_rec.interval = ival;
        m_rec_valid    = 1;
        m_done++;
        if (lat < m_min) m_min = lat;
        if (lat > m_max) m_max = lat;
    endtask

    task automatic model_step(input bit s, input bit r, input bit d, input bit c, input bit f);
        bit acc, bypassed;
        logic [CNT_W-1:0] ts, ival, hts, hint;
        m_rec_valid = 0;
        if (m_fin || f) begin
            m_fin = 1;
            return;
        end
        acc = 0; bypassed = 0; ts = m_now;
        if (!m_pending) begin
            if (s && r) acc = 1;
            else if (s) begin m_pending = 1; m_pend_ts = m_now; end
        end else if (r) begin
            acc = 1; ts = m_pend_ts; m_pending = 0;
        end else if (!s) begin
            m_pending = 0;
        end
        ival = m_has_acc ? m_now - m_last_acc : 0;
        if (d && !c) m_stall++;
        if (d && c) begin
            if (m_q.size() > 0) begin
                {hts, hint} = m_q.pop_front();
                model_record(hts, hint);
            end else if (acc) begin
                model_record(ts, ival);
                bypassed = 1;
            end else begin
                m_unf = 1;
            end
        end
        if (acc) begin
            m_started++;
            m_last_acc = m_now;
            m_has_acc  = 1;
            if (!bypassed) begin
                if (m_q.size() < DEPTH) m_q.push_back({ts, ival});
                else m_ovf = 1;
            end
        end
        m_now++;
    endtask

    task automatic compare_all();
        check_val("rec_valid", 32'(rec_valid), 32'(m_rec_valid));
        if (m_rec_valid) begin
            check_val("rec_index", rec_index, m_rec.index);
            check_val("rec_latency", rec_latency, m_rec.latency);
            check_val("rec_interval", rec_interval, m_rec.interval);
        end
        if (rec_valid)
            $display("rec idx=%0d lat=%0d ival=%0d t=%0t", rec_index, rec_latency, rec_interval, $time);
        check_val("started_cnt", started_cnt, m_started);
        check_val("done_cnt", done_cnt, m_done);
        check_val("min_lat", min_lat, m_min);
        check_val("max_lat", max_lat, m_max);
        check_val("stall_cycles", stall_cycles, m_stall);
        check_val("in_flight", 32'(in_flight), 32'(m_q.size()));
        check_val("busy", 32'(busy), 32'(m_pending || m_q.size() != 0));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("underflow", 32'(underflow), 32'(m_unf));
        check_val("finished", 32'(finished), 32'(m_fin));
    endtask

    task automatic cycle(input bit s, input bit r, input bit d, input bit c, input bit f);
        hs.ap_start = s; hs.ap_ready = r; hs.ap_done = d; hs.ap_continue = c; hs.finish = f;
        @(posedge clock);
        model_step(s, r, d, c, f);
        #1;
        compare_all();
    endtask

    task automatic idle_until(input int n);
        while (m_now < 32'(n)) cycle(0, 0, 0, 1, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        hs.ap_start = 0; hs.ap_ready = 0; hs.ap_done = 0; hs.ap_continue = 1; hs.finish = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Single ap_ctrl_hs transaction
        apply_reset();
        check_val("reset_min_lat", min_lat, 32'hFFFF_FFFF);
        idle_until(5);
        cycle(1, 1, 0, 1, 0);
        idle_until(14);
        cycle(0, 0, 1, 1, 0);
        check_val("t1_valid", 32'(rec_valid), 1);
        check_val("t1_latency", rec_latency, 10);
        check_val("t1_index", rec_index, 0);
        check_val("t1_interval", rec_interval, 0);
        cycle(0, 0, 0, 1, 0);
        check_val("t1_pulse_end", 32'(rec_valid), 0);

        // Pending start: request from 3, ready at 6, done at 8
        apply_reset();
        idle_until(3);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 1, 0);
            check_val("t2_pending_busy", 32'(busy), 1);
        end
        cycle(1, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        check_val("t2_latency", rec_latency, 6);

        // Pipelined II=2
        apply_reset();
        idle_until(10);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, 0, 1, 0);
            if (k < 3) cycle(0, 0, 0, 1, 0);
        end
        check_val("t3_in_flight_peak", 32'(in_flight), 4);
        idle_until(20);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, 1, 0);
            check_val("t3_latency", rec_latency, 11);
            check_val("t3_interval", rec_interval, (k == 0) ? 0 : 2);
            cycle(0, 0, 0, 1, 0);
        end

        // Backpressure
        apply_reset();
        idle_until(25);
        cycle(1, 1, 0, 1, 0);
        idle_until(30);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        check_val("t4_stall", stall_cycles, 3);
        check_val("t4_latency", rec_latency, 9);

        // Underflow, then overflow
        apply_reset();
        cycle(0, 0, 1, 1, 0);
        check_val("t5_underflow", 32'(underflow), 1);
        check_val("t5_done_cnt", done_cnt, 0);
        for (int k = 0; k < DEPTH + 1; k++) cycle(1, 1, 0, 1, 0);
        check_val("t5_overflow", 32'(overflow), 1);
        check_val("t5_in_flight", 32'(in_flight), DEPTH);
        check_val("t5_started", started_cnt, DEPTH + 1);

        // Finish freezes everything
        apply_reset();
        idle_until(40);
        cycle(1, 1, 0, 1, 0);
        idle_until(50);
        cycle(1, 1, 1, 1, 1);
        for (int k = 0; k < 6; k++) cycle(1, 1, 1, k[0], 0);
        check_val("t6_finished", 32'(finished), 1);
        check_val("t6_started", started_cnt, 1);
        check_val("t6_done", done_cnt, 0);
        check_val("t6_stall", stall_cycles, 0);

        // Reset mid-flight
        apply_reset();
        cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 0, 1, 0);
        apply_reset();
        check_val("t7_in_flight", 32'(in_flight), 0);
        check_val("t7_min_lat", min_lat, 32'hFFFF_FFFF);

        // Randomized traffic
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 0);
        end
        cycle(1, 1, 1, 1, 1);
        for (int k = 0; k < 10; k++) begin
            cycle($urandom_range(0, 1) == 1, 1, 1, $urandom_range(0, 1) == 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_status_tracker.md
# ap_ctrl_status_tracker

Synthesizable monitor for one HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue). It timestamps accepted transactions, matches them to completions through an in-flight FIFO, and reports per-transaction latency, acceptance interval and aggregate statistics. It sits beside each top-level or pipelined sub-function instance in the simulation or debug harness. Multiple instances run in parallel and are frozen by a common finish signal.

## Interface
- CNT_W, 32: width of the cycle counter, timestamps, latencies and statistics.
- DEPTH, 8: in-flight FIFO depth, a power of two ≥ 2.
- clock  in  1  sole clock; all logic samples on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ap_start  in  1  start request of the watched block.
- ap_ready  in  1  watched block has accepted its inputs.
- ap_done  in  1  watched block has finished a transaction.
- ap_continue  in  1  downstream acknowledge; tie to 1 for ap_ctrl_hs blocks.
- finish  in  1  end of run; freezes the monitor.
- rec_valid  out  1  one-cycle pulse carrying one completed-transaction record.
- rec_index  out  CNT_W  0-based index of the completed transaction.
- rec_latency  out  CNT_W  cycles from start request to completion.
- rec_interval  out  CNT_W  cycles between this transaction's acceptance and the previous acceptance; 0 for the first.
- started_cnt, done_cnt  out  CNT_W  counts of accepted and completed transactions.
- min_lat, max_lat  out  CNT_W  latency extremes; min resets to all-ones.
- stall_cycles  out  CNT_W  cycles with ap_done=1 and ap_continue=0.
- in_flight  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  start pending or in_flight≠0.
- overflow, underflow, finished  out  1  sticky flags.

## Operation
- Free-running cycle counter `now`: 0 in reset, +1 per cycle, wraps modulo 2^CNT_W. Latency and interval subtraction is modulo 2^CNT_W.
- Start state machine:
  - IDLE → PENDING when ap_start=1 and ap_ready=0; records t_s=now.
  - In IDLE, ap_start=1 and ap_ready=1 is an immediate accept with t_s=now.
  - PENDING → IDLE on ap_ready=1 (accept) or on ap_start dropping (abandoned; nothing counted).
- Accept:
  - push t_s to the FIFO, increment started_cnt, update last-accept time.
  - interval = now − previous accept time; 0 for the first accept.
  - Each pushed entry carries its interval.
- Completion = ap_done ∧ ap_continue:
  - pop FIFO head; latency = now − head.t_s + 1.
  - emit a record with rec_index = done_cnt, then increment done_cnt; update min/max.
- Same-cycle accept and completion with an empty FIFO: bypass. The record uses the current t_s and no push occurs.
- Completion with an empty FIFO and no bypass: set underflow; no record, no count change.
- Push when the FIFO is full and no pop occurs in that cycle: set overflow; the entry is dropped and started_cnt still increments.
- finish=1 sampled: set finished. All counters, FIFO and flags freeze from that cycle on (that cycle's events are ignored); rec_valid is held 0.
- Reset mid-transaction discards in-flight entries. All outputs return to 0, except min_lat, which returns to all-ones.

## Timing
- All outputs are registered. The record and its counters update on the edge after the sampling cycle, so rec_valid is high exactly one cycle after the completion cycle.
- Minimum latency is 1: start, ready and done all in the same cycle.
- Throughput: one accept and one completion per cycle, sustained.
- stall_cycles increments in every unfrozen cycle with ap_done=1 and ap_continue=0.

## Structure
- Shared package holds:
  - the state enum (IDLE, PENDING);
  - the record struct {index, latency, interval};
  - default widths.
- One sub-module, ts_fifo:
  - synchronous DEPTH-entry FIFO of {t_s, interval};
  - simultaneous push/pop allowed;
  - full/empty and count outputs.

## Test plan
- Single ap_ctrl_hs transaction: ap_start at cycle 5, ap_ready at 5, ap_done at 14 → rec_valid at 15, latency 10, index 0, interval 0.
- Pending start: ap_start from cycle 3, ap_ready at 6, done at 8 → latency 6; PENDING asserted during cycles 3–5.
- Pipelined II=2: accepts at 10, 12, 14, 16; dones at 20, 22, 24, 26 → four records, latency 11 each, intervals 0, 2, 2, 2; in_flight peaks at 4.
- Backpressure: ap_done high at 30–33 with ap_continue low until 33 → stall_cycles=3; one record with latency computed at cycle 33.
- Error paths: done with nothing in flight → underflow=1, done_cnt unchanged. DEPTH+1 accepts with no done → overflow=1, in_flight=DEPTH.
- finish at cycle 50, then further start/done activity → all counters unchanged, finished=1. Reset asserted mid-flight → in_flight=0, min_lat all-ones.
